// File: rtl/minmax_scheduler_if.sv
// ============================================================================
// Module   : minmax_scheduler_if
// Brief    : Sample-in / result-out handshake bundle for minmax_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface minmax_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] max_val;
    logic [IDX_W-1:0] max_idx;
    logic [WIDTH-1:0] min_val;
    logic [IDX_W-1:0] min_idx;
    logic             busy;

    // Sample source / result consumer side
    modport master (
        output in_data, in_valid, abort, out_ready,
        input  in_ready, out_valid, max_val, max_idx, min_val, min_idx, busy
    );

    // Tracker side
    modport slave (
        input  in_data, in_valid, abort, out_ready,
        output in_ready, out_valid, max_val, max_idx, min_val, min_idx, busy
    );
endinterface

`default_nettype wire

// File: rtl/minmax_scheduler.sv
// ============================================================================
// Module   : minmax_scheduler
// Brief    : Frame min/max tracker sharing one comparator between the max and
//            min compares. Define MINMAX_SIGNED_EN for two's-complement samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minmax_scheduler #(
    parameter int WIDTH = 8,
    parameter int COUNT = 16,
    parameter int IDX_W = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    minmax_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_MAX  = 2'd1,
        S_MIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(COUNT - 1);

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [WIDTH-1:0] sample_q,    sample_d;
    logic [WIDTH-1:0] max_val_q,   max_val_d;
    logic [IDX_W-1:0] max_idx_q,   max_idx_d;
    logic [WIDTH-1:0] min_val_q,   min_val_d;
    logic [IDX_W-1:0] min_idx_q,   min_idx_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] w_cmp_a;
    logic [WIDTH-1:0] w_cmp_b;
    logic [WIDTH:0]   w_diff;
    logic             w_lower;
    logic             w_equal;
    logic             w_greater;

    // Single shared comparator; operand B follows the compare phase.
    always_comb begin
`ifdef MINMAX_SIGNED_EN
        // Flipping the MSB maps two's complement onto unsigned ordering.
        w_cmp_a = sample_q ^ (WIDTH'(1) << (WIDTH - 1));
        w_cmp_b = ((state_q == S_MAX) ? max_val_q : min_val_q) ^ (WIDTH'(1) << (WIDTH - 1));
`else
        w_cmp_a = sample_q;
        w_cmp_b = (state_q == S_MAX) ? max_val_q : min_val_q;
`endif
        w_diff    = {1'b0, w_cmp_a} - {1'b0, w_cmp_b};
        w_equal   = (w_diff == '0);
        w_lower   = w_diff[WIDTH];
        w_greater = !w_lower && !w_equal;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sample_d  = sample_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        min_val_d = min_val_q;
        min_idx_d = min_idx_q;

        if (bus.abort) begin
            state_d = S_WAIT;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (bus.in_valid) begin
                        if (idx_q == '0) begin
                            // First sample seeds both trackers without a compare.
                            max_val_d = bus.in_data;
                            min_val_d = bus.in_data;
                            max_idx_d = '0;
                            min_idx_d = '0;
                            if (COUNT == 1) begin
                                state_d = S_DONE;
                            end else begin
                                idx_d = IDX_W'(1);
                            end
                        end else begin
                            sample_d = bus.in_data;
                            state_d  = S_MAX;
                        end
                    end
                end
                S_MAX: begin
                    if (w_greater) begin
                        max_val_d = sample_q;
                        max_idx_d = idx_q;
                    end
                    state_d = S_MIN;
                end
                S_MIN: begin
                    if (w_lower) begin
                        min_val_d = sample_q;
                        min_idx_d = idx_q;
                    end
                    if (idx_q == c_last_idx) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_WAIT;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end

        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT;
            idx_q       <= '0;
            sample_q    <= '0;
            max_val_q   <= '0;
            max_idx_q   <= '0;
            min_val_q   <= '0;
            min_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sample_q    <= sample_d;
            max_val_q   <= max_val_d;
            max_idx_q   <= max_idx_d;
            min_val_q   <= min_val_d;
            min_idx_q   <= min_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is held low while reset is asserted.
    assign bus.in_ready  = (state_q == S_WAIT) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != S_WAIT) || (idx_q != '0);
    assign bus.max_val   = max_val_q;
    assign bus.max_idx   = max_idx_q;
    assign bus.min_val   = min_val_q;
    assign bus.min_idx   = min_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_minmax_scheduler.sv
// ============================================================================
// Module   : tb_minmax_scheduler
// Brief    : Directed table-driven bench for minmax_scheduler (COUNT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minmax_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   t_acc = 0;
    int   t_first = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    minmax_scheduler_if #(.WIDTH(8), .IDX_W(2)) bus ();

    minmax_scheduler #(.WIDTH(8), .COUNT(4), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0][7:0] s;
        logic [7:0]      mx;
        logic [1:0]      mxi;
        logic [7:0]      mn;
        logic [1:0]      mni;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mkv(input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3,
                                 input logic [7:0] mx, input logic [1:0] mxi,
                                 input logic [7:0] mn, input logic [1:0] mni);
        vec_t v;
        v.s[0] = d0; v.s[1] = d1; v.s[2] = d2; v.s[3] = d3;
        v.mx = mx; v.mxi = mxi; v.mn = mn; v.mni = mni;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int g;
        g = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 20) begin
            step();
            g++;
        end
        if (g >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
        step();
        t_acc = cyc;
    endtask

    task automatic wait_ov();
        int g;
        g = 0;
        while (!bus.out_valid && g < 20) begin
            step();
            g++;
        end
        if (g >= 20) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        for (int j = 0; j < 4; j++) begin
            send(v.s[j]);
            if (j == 0) t_first = t_acc;
        end
        bus.in_valid = 1'b0;
        wait_ov();
        chk({tag, "_latency"}, cyc - t_acc, 2);
        chk({tag, "_max_val"}, v.mx, v.mx == bus.max_val ? v.mx : bus.max_val);
        chk({tag, "_max_idx"}, bus.max_idx, v.mxi);
        chk({tag, "_min_val"}, bus.min_val, v.mn);
        chk({tag, "_min_idx"}, bus.min_idx, v.mni);
        step();
        chk({tag, "_ov_drop"}, bus.out_valid, 0);
    endtask

    initial begin
`ifdef MINMAX_SIGNED_EN
        vecs[0] = mkv(8'd10, 8'd200, 8'd3, 8'd200, 8'd10, 2'd0, 8'd200, 2'd1);
        vecs[2] = mkv(8'h80, 8'h7F, 8'h00, 8'hFF, 8'h7F, 2'd1, 8'h80, 2'd0);
`else
        vecs[0] = mkv(8'd10, 8'd200, 8'd3, 8'd200, 8'd200, 2'd1, 8'd3, 2'd2);
        vecs[2] = mkv(8'h80, 8'h7F, 8'h00, 8'hFF, 8'hFF, 2'd3, 8'h00, 2'd2);
`endif
        vecs[1] = mkv(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 2'd0, 8'd5, 2'd0);
        vecs[3] = mkv(8'd9, 8'd1, 8'd9, 8'd0, 8'd9, 2'd0, 8'd0, 2'd3);
        vecs[4] = mkv(8'd7, 8'd7, 8'd2, 8'd2, 8'd7, 2'd0, 8'd2, 2'd2);

        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_max_val", bus.max_val, 0);
        chk("rst_min_val", bus.min_val, 0);
        #4 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        step();

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) chk("vec0_total_cycles", t_acc + 2 - t_first, 9);
        end

        // Consumer back-pressure with a source that keeps offering data
        bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) send(8'(j + 1));
        bus.in_data = 8'd77;
        wait_ov();
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_max", {bus.max_idx, bus.max_val}, {2'd3, 8'd4});
            chk("bp_min", {bus.min_idx, bus.min_val}, {2'd0, 8'd1});
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_hs_out_valid", bus.out_valid, 0);
        chk("bp_hs_in_ready", bus.in_ready, 1);
        chk("bp_hs_max_kept", bus.max_val, 4);
        step();
        chk("bp_next_busy", bus.busy, 1);
        chk("bp_next_max", bus.max_val, 77);
        chk("bp_next_min", bus.min_val, 77);
        bus.in_valid = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("bp_abort_busy", bus.busy, 0);

        // Abort during the max compare of the second sample
        send(8'd9);
        send(8'd7);
        bus.in_valid = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        run_frame(mkv(8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 2'd3, 8'd1, 2'd0), "post_abort");

        // Asynchronous reset during the min compare of the second sample
        send(8'd50);
        send(8'd60);
        bus.in_valid = 1'b0;
        step();
        chk("pre_arst_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_vals", {bus.max_val, bus.min_val}, 0);
        chk("arst_idx", {bus.max_idx, bus.min_idx}, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_rel_in_ready", bus.in_ready, 1);
        step();
        run_frame(vecs[3], "post_arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
